writeback_multi: RTL and testbench

N-lane in-order writeback/commit stage for the multi-issue pipeline. It sits after memory2 and registers one bundle of up to NUM_LANES instructions. It drives one regfile write port per lane and a single CSR write port. It adds three things the single-lane stage lacks: intra-bundle WAW resolution, precise exception cut-off inside a bundle, and a retired-instruction counter.

---
 rtl/writeback_multi.sv | 159 +++++++++++++++
 tb/tb_writeback_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_multi.sv
// writeback_multi: N-lane in-order writeback/commit stage for the multi-issue pipeline.
//
// Registers one bundle of up to NUM_LANES instructions (lane 0 oldest) and commits it
// when the stage is neither empty nor flushed and downstream is ready.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kills the registered bundle
//   next_rdy_in         downstream ready
//   rdy_in              stage ready; upstream bundle is captured when high
//   pass_*              per-lane upstream bundle fields (lane i at slice i)
//   reg_idx/we/data     one regfile write port per lane
//   csr_addr/we/data    single CSR write port
//   excp_flush/excp_pc  registered pulse and pc of the faulting lane
//   instret             retired instruction counter
module writeback_multi #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int CSR_AW    = 14,
    parameter int CNT_W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       next_rdy_in,
    output logic                       rdy_in,
    input  logic [NUM_LANES-1:0]       pass_valid,
    input  logic [NUM_LANES*5-1:0]     pass_rd,
    input  logic [NUM_LANES-1:0]       pass_is_wr_rd,
    input  logic [NUM_LANES-1:0]       pass_wr_pc4,
    input  logic [NUM_LANES*XLEN-1:0]  pass_result,
    input  logic [NUM_LANES*XLEN-1:0]  pass_pc,
    input  logic [NUM_LANES-1:0]       pass_is_wr_csr,
    input  logic [NUM_LANES*CSR_AW-1:0] pass_csr_addr,
    input  logic [NUM_LANES-1:0]       pass_excp,
    output logic [NUM_LANES*5-1:0]     reg_idx,
    output logic [NUM_LANES-1:0]       reg_we,
    output logic [NUM_LANES*XLEN-1:0]  reg_data,
    output logic [CSR_AW-1:0]          csr_addr,
    output logic                       csr_we,
    output logic [XLEN-1:0]            csr_data,
    output logic                       excp_flush,
    output logic [XLEN-1:0]            excp_pc,
    output logic [CNT_W-1:0]           instret
);
    localparam int LW = $clog2(NUM_LANES + 1);

    logic [NUM_LANES-1:0]       valid_q;
    logic [NUM_LANES*5-1:0]     rd_q;
    logic [NUM_LANES-1:0]       is_wr_rd_q;
    logic [NUM_LANES-1:0]       wr_pc4_q;
    logic [NUM_LANES*XLEN-1:0]  result_q;
    logic [NUM_LANES*XLEN-1:0]  pc_q;
    logic [NUM_LANES-1:0]       is_wr_csr_q;
    logic [NUM_LANES*CSR_AW-1:0] csr_addr_q;
    logic [NUM_LANES-1:0]       excp_q;

    logic                       empty;
    logic                       kill;
    logic                       fire;
    logic [NUM_LANES-1:0]       commit;
    logic [NUM_LANES-1:0]       we_raw;
    logic                       excp_any;
    logic [XLEN-1:0]            fault_pc;
    logic [LW-1:0]              n_commit;

    assign empty  = ~|valid_q;
    assign kill   = flush | empty;
    assign rdy_in = kill | next_rdy_in;
    assign fire   = ~kill & next_rdy_in;
    assign reg_idx = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            rd_q        <= '0;
            is_wr_rd_q  <= '0;
            wr_pc4_q    <= '0;
            result_q    <= '0;
            pc_q        <= '0;
            is_wr_csr_q <= '0;
            csr_addr_q  <= '0;
            excp_q      <= '0;
        end else if (rdy_in) begin
            valid_q     <= pass_valid;
            rd_q        <= pass_rd;
            is_wr_rd_q  <= pass_is_wr_rd;
            wr_pc4_q    <= pass_wr_pc4;
            result_q    <= pass_result;
            pc_q        <= pass_pc;
            is_wr_csr_q <= pass_is_wr_csr;
            csr_addr_q  <= pass_csr_addr;
            excp_q      <= pass_excp;
        end
    end

    // Commit mask: a lane commits only if no valid lane at or below it faulted.
    // Invalid lanes are skipped and never stop younger lanes.
    always_comb begin
        logic seen;
        seen     = 1'b0;
        commit   = '0;
        we_raw   = '0;
        excp_any = 1'b0;
        fault_pc = '0;
        n_commit = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (valid_q[i] && excp_q[i] && !seen)
                fault_pc = pc_q[i*XLEN +: XLEN];
            seen      = seen | (valid_q[i] & excp_q[i]);
            commit[i] = fire & valid_q[i] & ~seen;
            we_raw[i] = commit[i] & is_wr_rd_q[i] & (rd_q[i*5 +: 5] != 5'd0);
            n_commit  = n_commit + LW'(commit[i]);
        end
        excp_any = seen;
    end

    // Intra-bundle WAW: an older write is dropped when a younger lane writes the same rd.
    always_comb begin
        reg_we = we_raw;
        for (int i = 0; i < NUM_LANES; i++)
            for (int j = i + 1; j < NUM_LANES; j++)
                if (we_raw[j] && rd_q[j*5 +: 5] == rd_q[i*5 +: 5])
                    reg_we[i] = 1'b0;
    end

    always_comb begin
        reg_data = '0;
        for (int i = 0; i < NUM_LANES; i++)
            reg_data[i*XLEN +: XLEN] = wr_pc4_q[i] ? pc_q[i*XLEN +: XLEN] + XLEN'(4)
                                                   : result_q[i*XLEN +: XLEN];
    end

    // Scan youngest to oldest so the lowest-index committed CSR writer is left selected.
    always_comb begin
        csr_we   = 1'b0;
        csr_addr = csr_addr_q[0 +: CSR_AW];
        csr_data = result_q[0 +: XLEN];
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (commit[i] && is_wr_csr_q[i]) begin
                csr_we   = 1'b1;
                csr_addr = csr_addr_q[i*CSR_AW +: CSR_AW];
                csr_data = result_q[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret    <= '0;
            excp_flush <= 1'b0;
            excp_pc    <= '0;
        end else begin
            excp_flush <= fire & excp_any;
            if (fire)
                instret <= instret + CNT_W'(n_commit);
            if (fire && excp_any)
                excp_pc <= fault_pc;
        end
    end
endmodule

// File: tb/tb_writeback_multi.sv
// tb_writeback_multi: directed scoreboard bench for writeback_multi (2 lanes).
//
// A second instance with a 3-bit instret shares the stimulus so counter wrap is
// reached within a short run.
module tb_writeback_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        next_rdy_in;
    logic        rdy_in;
    logic [1:0]  pass_valid;
    logic [9:0]  pass_rd;
    logic [1:0]  pass_is_wr_rd;
    logic [1:0]  pass_wr_pc4;
    logic [63:0] pass_result;
    logic [63:0] pass_pc;
    logic [1:0]  pass_is_wr_csr;
    logic [27:0] pass_csr_addr;
    logic [1:0]  pass_excp;
    logic [9:0]  reg_idx;
    logic [1:0]  reg_we;
    logic [63:0] reg_data;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_data;
    logic        excp_flush;
    logic [31:0] excp_pc;
    logic [63:0] instret;

    logic        w_rdy_in;
    logic [9:0]  w_reg_idx;
    logic [1:0]  w_reg_we;
    logic [63:0] w_reg_data;
    logic [13:0] w_csr_addr;
    logic        w_csr_we;
    logic [31:0] w_csr_data;
    logic        w_excp_flush;
    logic [31:0] w_excp_pc;
    logic [2:0]  w_instret;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] cnt   = '0;

    typedef struct {
        logic [1:0]  we;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        cwe;
        logic [13:0] ca;
        logic [31:0] cd;
        int          inc;
        logic        exf;
        logic [31:0] epc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    writeback_multi #(.NUM_LANES(2), .XLEN(32), .CSR_AW(14), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .next_rdy_in(next_rdy_in), .rdy_in(rdy_in),
        .pass_valid(pass_valid), .pass_rd(pass_rd), .pass_is_wr_rd(pass_is_wr_rd),
        .pass_wr_pc4(pass_wr_pc4), .pass_result(pass_result), .pass_pc(pass_pc),
        .pass_is_wr_csr(pass_is_wr_csr), .pass_csr_addr(pass_csr_addr), .pass_excp(pass_excp),
        .reg_idx(reg_idx), .reg_we(reg_we), .reg_data(reg_data),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_data(csr_data),
        .excp_flush(excp_flush), .excp_pc(excp_pc), .instret(instret)
    );

    writeback_multi #(.NUM_LANES(2), .XLEN(32), .CSR_AW(14), .CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .next_rdy_in(next_rdy_in), .rdy_in(w_rdy_in),
        .pass_valid(pass_valid), .pass_rd(pass_rd), .pass_is_wr_rd(pass_is_wr_rd),
        .pass_wr_pc4(pass_wr_pc4), .pass_result(pass_result), .pass_pc(pass_pc),
        .pass_is_wr_csr(pass_is_wr_csr), .pass_csr_addr(pass_csr_addr), .pass_excp(pass_excp),
        .reg_idx(w_reg_idx), .reg_we(w_reg_we), .reg_data(w_reg_data),
        .csr_addr(w_csr_addr), .csr_we(w_csr_we), .csr_data(w_csr_data),
        .excp_flush(w_excp_flush), .excp_pc(w_excp_pc), .instret(w_instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        pass_valid = '0; pass_rd = '0; pass_is_wr_rd = '0; pass_wr_pc4 = '0;
        pass_result = '0; pass_pc = '0; pass_is_wr_csr = '0; pass_csr_addr = '0;
        pass_excp = '0;
    endtask

    task automatic lane(input int i, input logic v, input logic [4:0] rd, input logic wrd,
                        input logic pc4, input logic [31:0] res, input logic [31:0] pc,
                        input logic wc, input logic [13:0] ca, input logic ex);
        pass_valid[i] = v; pass_rd[i*5 +: 5] = rd; pass_is_wr_rd[i] = wrd;
        pass_wr_pc4[i] = pc4; pass_result[i*32 +: 32] = res; pass_pc[i*32 +: 32] = pc;
        pass_is_wr_csr[i] = wc; pass_csr_addr[i*14 +: 14] = ca; pass_excp[i] = ex;
    endtask

    task automatic push(input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1,
                        input logic cwe, input logic [13:0] ca, input logic [31:0] cd,
                        input int inc, input logic exf, input logic [31:0] epc);
        exp_t e;
        e = '{we, d0, d1, cwe, ca, cd, inc, exf, epc};
        sb.push_back(e);
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".reg_we"}, 64'(reg_we), 64'(e.we));
        if (e.we[0]) chk({tag, ".data0"}, 64'(reg_data[31:0]), 64'(e.d0));
        if (e.we[1]) chk({tag, ".data1"}, 64'(reg_data[63:32]), 64'(e.d1));
        chk({tag, ".csr_we"}, 64'(csr_we), 64'(e.cwe));
        if (e.cwe) begin
            chk({tag, ".csr_addr"}, 64'(csr_addr), 64'(e.ca));
            chk({tag, ".csr_data"}, 64'(csr_data), 64'(e.cd));
        end
    endtask

    task automatic cmp_commit(input string tag, input exp_t e);
        cnt = cnt + 64'(e.inc);
        chk({tag, ".instret"}, instret, cnt);
        chk({tag, ".instret_w"}, 64'(w_instret), 64'(cnt[2:0]));
        chk({tag, ".excp_flush"}, 64'(excp_flush), 64'(e.exf));
        if (e.exf) chk({tag, ".excp_pc"}, 64'(excp_pc), 64'(e.epc));
    endtask

    // Bundle already driven and expectation pushed: capture, check writes, commit, check counters.
    task automatic go(input string tag);
        exp_t e;
        @(posedge clk); #1;
        pass_valid = '0;
        e = sb.pop_front();
        cmp_out(tag, e);
        @(posedge clk); #1;
        cmp_commit(tag, e);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; flush = 1'b0; next_rdy_in = 1'b1;
        clear();
        #2;
        chk("rst.rdy_in", 64'(rdy_in), 64'd1);
        chk("rst.reg_we", 64'(reg_we), 64'd0);
        chk("rst.csr_we", 64'(csr_we), 64'd0);
        chk("rst.excp_flush", 64'(excp_flush), 64'd0);
        chk("rst.excp_pc", 64'(excp_pc), 64'd0);
        chk("rst.instret", instret, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        clear();
        lane(0, 1, 5'd3, 1, 0, 32'h11, 32'h1c000000, 0, 14'h0, 0);
        lane(1, 1, 5'd5, 1, 0, 32'h22, 32'h1c000004, 0, 14'h0, 0);
        push(2'b11, 32'h11, 32'h22, 0, 14'h0, 32'h0, 2, 0, 32'h0);
        go("t1");

        clear();
        lane(0, 1, 5'd7, 1, 0, 32'hAA, 32'h1c000008, 0, 14'h0, 0);
        lane(1, 1, 5'd7, 1, 0, 32'hBB, 32'h1c00000c, 0, 14'h0, 0);
        push(2'b10, 32'h0, 32'hBB, 0, 14'h0, 32'h0, 2, 0, 32'h0);
        go("t2_waw");

        clear();
        lane(0, 1, 5'd2, 1, 0, 32'h99, 32'h1c000100, 0, 14'h0, 1);
        lane(1, 1, 5'd4, 1, 0, 32'h12, 32'h1c000104, 1, 14'h340, 0);
        push(2'b00, 32'h0, 32'h0, 0, 14'h0, 32'h0, 0, 1, 32'h1c000100);
        go("t3_excp0");

        clear();
        lane(0, 1, 5'd6, 1, 0, 32'h33, 32'h1c000200, 0, 14'h0, 0);
        lane(1, 1, 5'd8, 1, 0, 32'h34, 32'h1c000204, 0, 14'h0, 1);
        push(2'b01, 32'h33, 32'h0, 0, 14'h0, 32'h0, 1, 1, 32'h1c000204);
        go("t3_excp1");

        clear();
        lane(0, 1, 5'd12, 1, 0, 32'h44, 32'h1c000300, 0, 14'h0, 0);
        lane(1, 1, 5'd0, 0, 0, 32'h55, 32'h1c000304, 1, 14'h300, 0);
        next_rdy_in = 1'b0;
        push(2'b01, 32'h44, 32'h0, 1, 14'h300, 32'h55, 2, 0, 32'h0);
        @(posedge clk); #1;
        pass_valid = '0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_stall.rdy_in", 64'(rdy_in), 64'd0);
            chk("t4_stall.reg_we", 64'(reg_we), 64'd0);
            chk("t4_stall.csr_we", 64'(csr_we), 64'd0);
            chk("t4_stall.instret", instret, cnt);
            @(posedge clk); #1;
        end
        next_rdy_in = 1'b1;
        #1;
        e = sb.pop_front();
        cmp_out("t4_release", e);
        @(posedge clk); #1;
        cmp_commit("t4_release", e);
        chk("t4_after.reg_we", 64'(reg_we), 64'd0);

        clear();
        lane(0, 1, 5'd1, 1, 0, 32'h66, 32'h1c000400, 0, 14'h0, 1);
        lane(1, 1, 5'd11, 1, 0, 32'h67, 32'h1c000404, 0, 14'h0, 0);
        next_rdy_in = 1'b0;
        @(posedge clk); #1;
        pass_valid = '0;
        chk("t5_stall.rdy_in", 64'(rdy_in), 64'd0);
        flush = 1'b1;
        #1;
        chk("t5_flush.rdy_in", 64'(rdy_in), 64'd1);
        chk("t5_flush.reg_we", 64'(reg_we), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        next_rdy_in = 1'b1;
        chk("t5_drop.instret", instret, cnt);
        chk("t5_drop.excp_flush", 64'(excp_flush), 64'd0);
        chk("t5_drop.rdy_in", 64'(rdy_in), 64'd1);

        clear();
        lane(0, 1, 5'd0, 1, 1, 32'h0, 32'hFFFFFFFC, 0, 14'h0, 0);
        push(2'b00, 32'h0, 32'h0, 0, 14'h0, 32'h0, 1, 0, 32'h0);
        go("t6_rd0");

        clear();
        lane(0, 1, 5'd9, 1, 1, 32'h5, 32'hFFFFFFFC, 0, 14'h0, 0);
        push(2'b01, 32'h0, 32'h0, 0, 14'h0, 32'h0, 1, 0, 32'h0);
        go("t6_pc4wrap");

        clear();
        lane(0, 1, 5'd13, 1, 0, 32'h66, 32'h1c000500, 1, 14'h301, 0);
        lane(1, 1, 5'd14, 1, 0, 32'h77, 32'h1c000504, 1, 14'h302, 0);
        push(2'b11, 32'h66, 32'h77, 1, 14'h301, 32'h66, 2, 0, 32'h0);
        go("t7_csr2");

        clear();
        lane(0, 0, 5'd10, 1, 0, 32'h1, 32'h1c000600, 1, 14'h3ff, 1);
        lane(1, 1, 5'd10, 1, 0, 32'h88, 32'h1c000604, 1, 14'h305, 0);
        push(2'b10, 32'h0, 32'h88, 1, 14'h305, 32'h88, 1, 0, 32'h0);
        go("t8_skip");

        chk("end.reg_idx1", 64'(reg_idx[9:5]), 64'd10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
